// File: rtl/floppy_req_sched.sv
// ============================================================================
// Module      : floppy_req_sched
// Description : Round-robin scheduler for floppy track-load requests onto the
//               single floppy_req IRQ channel, with ACK sniffing and retry.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module floppy_req_sched #(
  parameter logic [7:0] c_addr_ack     = 8'hD1,
  parameter int         c_pulse_len    = 4,
  parameter int         c_timeout_bits = 24,
  parameter int         c_retries      = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req0,
  input  logic        req1,
  input  logic [6:0]  track0,
  input  logic [6:0]  track1,
  input  logic        spi_wr,
  input  logic [31:0] spi_addr,
  output logic        floppy_req,
  output logic [7:0]  floppy_req_type,
  output logic        ready0,
  output logic        ready1,
  output logic        busy,
  output logic        err
);

  localparam int c_pulse_w = (c_pulse_len > 1) ? $clog2(c_pulse_len) : 1;
  localparam int c_retry_w = (c_retries > 0) ? $clog2(c_retries + 1) : 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2
  } state_t;

  state_t                      state_q, state_d;
  logic [1:0]                  pend_q, pend_d;
  logic [1:0][6:0]             pend_trk_q, pend_trk_d;
  logic [1:0][6:0]             loaded_trk_q, loaded_trk_d;
  logic [1:0]                  loaded_valid_q, loaded_valid_d;
  logic                        rr_q, rr_d;
  logic [7:0]                  type_q, type_d;
  logic [c_pulse_w-1:0]        pulse_cnt_q, pulse_cnt_d;
  logic [c_timeout_bits-1:0]   to_cnt_q, to_cnt_d;
  logic [c_retry_w-1:0]        retry_q, retry_d;
  logic                        err_q, err_d;
  logic [1:0]                  ready_q, ready_d;

  logic [1:0] req_v;
  logic       sel;
  logic       drv;
  logic       ack;
  logic       timeout;
  logic       unused_addr_bits;

  assign req_v            = {req1, req0};
  assign drv              = type_q[7];
  // Only the top address byte identifies the ACK register; the rest is payload.
  assign ack              = spi_wr && (spi_addr[31:24] == c_addr_ack);
  assign unused_addr_bits = ^spi_addr[23:0];
  assign timeout          = to_cnt_q[c_timeout_bits-1];

  assign busy            = (state_q == ST_ISSUE) || (state_q == ST_WAIT);
  assign floppy_req      = (state_q == ST_ISSUE);
  assign floppy_req_type = type_q;
  assign ready0          = ready_q[0];
  assign ready1          = ready_q[1];
  assign err             = err_q;

  always_comb begin
    state_d        = state_q;
    pend_d         = pend_q;
    pend_trk_d     = pend_trk_q;
    loaded_trk_d   = loaded_trk_q;
    loaded_valid_d = loaded_valid_q;
    rr_d           = rr_q;
    type_d         = type_q;
    pulse_cnt_d    = pulse_cnt_q;
    to_cnt_d       = to_cnt_q;
    retry_d        = retry_q;
    err_d          = err_q;
    sel            = rr_q;

    // Capture runs in every state; the in-flight request lives in type_q only.
    if (req0) begin
      pend_d[0]     = 1'b1;
      pend_trk_d[0] = track0;
    end
    if (req1) begin
      pend_d[1]     = 1'b1;
      pend_trk_d[1] = track1;
    end

    case (state_q)
      ST_IDLE: begin
        if (|pend_q) begin
          if (pend_q == 2'b01)      sel = 1'b0;
          else if (pend_q == 2'b10) sel = 1'b1;
          else                      sel = rr_q;
          type_d      = {sel, pend_trk_q[sel]};
          if (!req_v[sel]) pend_d[sel] = 1'b0;
          rr_d        = ~sel;
          pulse_cnt_d = '0;
          state_d     = ST_ISSUE;
        end
      end

      ST_ISSUE: begin
        if (pulse_cnt_q == c_pulse_w'(c_pulse_len - 1)) begin
          to_cnt_d = '0;
          state_d  = ST_WAIT;
        end else begin
          pulse_cnt_d = pulse_cnt_q + c_pulse_w'(1);
        end
      end

      ST_WAIT: begin
        if (ack) begin
          loaded_trk_d[drv]   = type_q[6:0];
          loaded_valid_d[drv] = 1'b1;
          retry_d             = '0;
          state_d             = ST_IDLE;
        end else if (timeout) begin
          if (int'(retry_q) < c_retries) begin
            retry_d     = retry_q + c_retry_w'(1);
            pulse_cnt_d = '0;
            state_d     = ST_ISSUE;
          end else begin
            err_d               = 1'b1;
            loaded_valid_d[drv] = 1'b0;
            retry_d             = '0;
            state_d             = ST_IDLE;
          end
        end else begin
          to_cnt_d = to_cnt_q + c_timeout_bits'(1);
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // Ready compares against the last requested track, so a newer request that
  // has not been served yet keeps the drive not-ready.
  always_comb begin
    ready_d = '0;
    for (int n = 0; n < 2; n++) begin
      ready_d[n] = loaded_valid_q[n] && !pend_q[n] && !(busy && (drv == n[0]))
                   && (loaded_trk_q[n] == pend_trk_q[n]);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= ST_IDLE;
      pend_q         <= '0;
      pend_trk_q     <= '0;
      loaded_trk_q   <= '0;
      loaded_valid_q <= '0;
      rr_q           <= 1'b0;
      type_q         <= '0;
      pulse_cnt_q    <= '0;
      to_cnt_q       <= '0;
      retry_q        <= '0;
      err_q          <= 1'b0;
      ready_q        <= '0;
    end else begin
      state_q        <= state_d;
      pend_q         <= pend_d;
      pend_trk_q     <= pend_trk_d;
      loaded_trk_q   <= loaded_trk_d;
      loaded_valid_q <= loaded_valid_d;
      rr_q           <= rr_d;
      type_q         <= type_d;
      pulse_cnt_q    <= pulse_cnt_d;
      to_cnt_q       <= to_cnt_d;
      retry_q        <= retry_d;
      err_q          <= err_d;
      ready_q        <= ready_d;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_floppy_req_sched.sv
// ============================================================================
// Module      : tb_floppy_req_sched
// Description : Directed bench for floppy_req_sched (short timeout build).
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_floppy_req_sched;

  logic        clk = 1'b0;
  logic        reset;
  logic        req0, req1;
  logic [6:0]  track0, track1;
  logic        spi_wr;
  logic [31:0] spi_addr;
  logic        floppy_req;
  logic [7:0]  floppy_req_type;
  logic        ready0, ready1, busy, err;

  floppy_req_sched #(
    .c_addr_ack    (8'hD1),
    .c_pulse_len   (4),
    .c_timeout_bits(4),
    .c_retries     (2)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .req0           (req0),
    .req1           (req1),
    .track0         (track0),
    .track1         (track1),
    .spi_wr         (spi_wr),
    .spi_addr       (spi_addr),
    .floppy_req     (floppy_req),
    .floppy_req_type(floppy_req_type),
    .ready0         (ready0),
    .ready1         (ready1),
    .busy           (busy),
    .err            (err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        drv;
    logic [6:0]  trk;
    logic [31:0] ack_addr;
    logic [7:0]  exp_type;
  } vec_t;

  vec_t vecs[4];
  int   n_checks = 0;
  int   n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; req0 = 1'b0; req1 = 1'b0; track0 = '0; track1 = '0;
    spi_wr = 1'b0; spi_addr = '0;
    cyc(); cyc();
    reset = 1'b0;
  endtask

  task automatic request(input logic drv, input logic [6:0] trk);
    if (drv) begin req1 = 1'b1; track1 = trk; end
    else     begin req0 = 1'b1; track0 = trk; end
    cyc();
    req0 = 1'b0; req1 = 1'b0;
  endtask

  // Waits (bounded) for floppy_req; returns cycles waited after the capture edge.
  task automatic wait_rise(input string name, output int waited);
    waited = 0;
    while (!floppy_req && waited < 30) begin
      cyc();
      waited++;
    end
    check({name, " pulse seen"}, floppy_req, 1);
  endtask

  task automatic pulse_len(output int len);
    len = 0;
    while (floppy_req && len < 30) begin
      cyc();
      len++;
    end
  endtask

  task automatic ack(input logic [31:0] addr);
    spi_wr = 1'b1; spi_addr = addr;
    cyc();
    spi_wr = 1'b0; spi_addr = '0;
  endtask

  task automatic watch_quiet(input string name, input int cycles);
    logic seen;
    seen = 1'b0;
    for (int k = 0; k < cycles; k++) begin
      cyc();
      if (floppy_req) seen = 1'b1;
    end
    check({name, " no further pulse"}, seen, 0);
  endtask

  initial begin
    int   w, len, idx, nr;
    int   rise_at[4];
    logic prev;

    vecs[0] = '{drv: 1'b0, trk: 7'd5,  ack_addr: 32'hD100_0000, exp_type: 8'h05};
    vecs[1] = '{drv: 1'b1, trk: 7'd79, ack_addr: 32'hD1FF_FFFF, exp_type: 8'hCF};
    vecs[2] = '{drv: 1'b0, trk: 7'd0,  ack_addr: 32'hD1AB_CDEF, exp_type: 8'h00};
    vecs[3] = '{drv: 1'b1, trk: 7'd42, ack_addr: 32'hD100_0001, exp_type: 8'hAA};

    do_reset();
    check("reset floppy_req", floppy_req, 0);
    check("reset type", floppy_req_type, 8'h00);
    check("reset ready", {ready1, ready0}, 2'b00);
    check("reset busy", busy, 0);
    check("reset err", err, 0);

    // Single requests: pulse one cycle after capture, 4 cycles long, then ACK.
    for (int i = 0; i < 4; i++) begin
      request(vecs[i].drv, vecs[i].trk);
      wait_rise($sformatf("vec%0d", i), w);
      check($sformatf("vec%0d grant latency", i), w, 1);
      check($sformatf("vec%0d type", i), floppy_req_type, vecs[i].exp_type);
      check($sformatf("vec%0d busy issue", i), busy, 1);
      pulse_len(len);
      check($sformatf("vec%0d pulse len", i), len, 4);
      check($sformatf("vec%0d busy wait", i), busy, 1);
      check($sformatf("vec%0d type stable", i), floppy_req_type, vecs[i].exp_type);
      ack(vecs[i].ack_addr);
      check($sformatf("vec%0d busy after ack", i), busy, 0);
      cyc();
      check($sformatf("vec%0d ready", i), vecs[i].drv ? ready1 : ready0, 1);
      check($sformatf("vec%0d err", i), err, 0);
    end

    // ACK during the pulse must be ignored.
    request(1'b0, 7'd33);
    wait_rise("ackiss", w);
    ack(32'hD100_0000);
    pulse_len(len);
    check("ackiss remaining pulse", len, 3);
    cyc();
    check("ackiss still busy", busy, 1);
    ack(32'hD100_0000);
    cyc();
    check("ackiss ready0", ready0, 1);

    // Test 2: simultaneous requests, rr=0 after reset -> drive 0 first.
    do_reset();
    req0 = 1'b1; track0 = 7'd3; req1 = 1'b1; track1 = 7'd10;
    cyc();
    req0 = 1'b0; req1 = 1'b0;
    wait_rise("rr first", w);
    check("rr first type", floppy_req_type, 8'h03);
    pulse_len(len);
    ack(32'hD100_0000);
    wait_rise("rr second", w);
    check("rr second type", floppy_req_type, 8'h8A);
    pulse_len(len);
    ack(32'hD100_0000);
    cyc();
    check("rr both ready", {ready1, ready0}, 2'b11);

    // Test 4: same track re-requested, never ACKed. Rises are
    // pulse(4) + 8 count cycles + timeout cycle = 13 cycles apart.
    request(1'b0, 7'd3);
    nr = 0; prev = 1'b0;
    for (idx = 0; idx < 60; idx++) begin
      if (floppy_req && !prev && nr < 4) begin
        rise_at[nr] = idx;
        nr++;
      end
      if (idx == 1) check("timeout ready0 while pending", ready0, 0);
      prev = floppy_req;
      cyc();
    end
    check("timeout pulse count", nr, 3);
    check("timeout spacing 1", rise_at[1] - rise_at[0], 13);
    check("timeout spacing 2", rise_at[2] - rise_at[1], 13);
    check("timeout err", err, 1);
    check("timeout busy", busy, 0);
    check("timeout ready0", ready0, 0);
    check("timeout ready1 kept", ready1, 1);

    // err is sticky across a later successful load.
    request(1'b1, 7'd1);
    wait_rise("sticky", w);
    pulse_len(len);
    ack(32'hD100_0000);
    cyc();
    check("sticky ready1", ready1, 1);
    check("sticky err", err, 1);

    // Test 3: newer request for the same drive while the old one is in WAIT.
    do_reset();
    request(1'b0, 7'd7);
    wait_rise("supersede", w);
    check("supersede type 7", floppy_req_type, 8'h07);
    pulse_len(len);
    request(1'b0, 7'd9);
    ack(32'hD100_0000);
    wait_rise("supersede reissue", w);
    check("supersede ready0 low", ready0, 0);
    check("supersede type 9", floppy_req_type, 8'h09);
    pulse_len(len);
    ack(32'hD100_0000);
    cyc();
    check("supersede ready0", ready0, 1);

    // Test 5: non-ACK addresses, then ACK exactly in the timeout cycle.
    do_reset();
    request(1'b1, 7'd20);
    wait_rise("race", w);
    check("race type", floppy_req_type, 8'h94);
    pulse_len(len);
    ack(32'hD000_0000);
    ack(32'hFB12_3456);
    repeat (6) cyc();
    check("race still busy", busy, 1);
    check("race no early retry", floppy_req, 0);
    ack(32'hD100_0000);
    check("race busy after ack", busy, 0);
    cyc();
    check("race ready1", ready1, 1);
    check("race err", err, 0);
    watch_quiet("race", 15);

    // Test 6: reset in the middle of the pulse.
    do_reset();
    request(1'b0, 7'd11);
    wait_rise("midrst", w);
    cyc();
    reset = 1'b1;
    cyc();
    check("midrst floppy_req", floppy_req, 0);
    check("midrst busy", busy, 0);
    check("midrst ready0", ready0, 0);
    check("midrst type", floppy_req_type, 8'h00);
    reset = 1'b0;
    watch_quiet("midrst", 20);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
